rice_demapper: RTL and testbench
================================

// Module: rice_demapper
// PURPOSE
//  - Final stage of the FLAC hardware decoder's Rice residual path.
//  - Takes the unary quotient (MSB part) and the k-bit binary remainder (LSB part) of one
//    Rice codeword and reassembles the unsigned folded value.
//  - Un-folds (zig-zag decodes) that value into a signed two's-complement residual.
//  - Registers the residual for the downstream LPC/fixed predictor.
// PARAMETERS
//  - DATA_W   16  width of iMSB, iLSB, internal folded value and oData
//  - PARAM_W  4   width of iRiceParam; supported k = 0 .. 2**PARAM_W-1
// PORTS
//  - Clocking/reset: one clock; reset is asynchronous and active-high.
//  - iClk        in   1        sole clock; all state updates on rising edge
//  - iRst        in   1        asynchronous, active-high reset
//  - iRiceParam  in   PARAM_W  Rice parameter k for the current codeword
//  - iMSB        in   DATA_W   quotient: count of unary zeros before the stop bit
//  - iLSB        in   DATA_W   remainder: k raw bits, right-aligned; bits >= k are ignored
//  - oData       out  DATA_W   signed two's-complement residual, registered
// BEHAVIOUR
//  - Reset: while iRst=1, oData=0 immediately, with no clock edge required.
//  - Reset release: oData holds 0 until the first rising edge after iRst deasserts.
//  - Fold, combinational: u = ((iMSB << k) | (iLSB & ((1<<k)-1))), truncated to DATA_W bits.
//    - Quotient bits shifted past bit DATA_W-1 are discarded.
//  - k=0: mask is 0, so iLSB is fully ignored and u = iMSB.
//  - Unfold, combinational:
//    - u[0]=0: r = u >> 1 (non-negative).
//    - u[0]=1: r = ~(u >> 1), i.e. -((u>>1)+1) (negative).
//    - Logical shift; no arithmetic carry beyond DATA_W.
//  - Register: oData <= r on every rising iClk while iRst=0.
//  - Latency and throughput:
//    - Inputs sampled at edge N appear on oData after edge N.
//    - One codeword per cycle, latency 1 clock.
//    - No handshake or valid signal; the block is free-running and the caller
//      tracks validity alongside the 1-cycle delay.
//  - Range limits:
//    - u=0xFFFF gives oData=0x8000 (-32768).
//    - u=0xFFFE gives oData=0x7FFF (+32767).
//    - u=0 gives oData=0.
//  - Input changes between edges have no effect on oData until the next rising edge.
//  - k=15: mask is 0x7FFF; only iMSB[0] survives into u[15].
// TESTING
//  - Reset: assert iRst mid-stream -> oData=0 asynchronously; first edge after release
//    loads the current input.
//  - k=0 sequence, one per cycle, each checked 1 clock later:
//    - iMSB = 2, 6, 3, 8, 14, 100, 203 (iLSB=0)
//    - expected oData = 1, 3, -2, 4, 7, 50, -102
//  - k=3 sequence, each checked 1 clock later:
//    - (iMSB, iLSB) = (0,2), (0,6), (0,3), (1,0), (1,6), (12,4), (25,3)
//    - expected oData = 1, 3, -2, 4, 7, 50, -102
//  - Masking: k=3, iMSB=1, iLSB=0xFFF8 -> u=8 -> oData=4.
//    k=0, iLSB=0xFFFF, iMSB=0 -> oData=0.
//  - Extremes:
//    - k=0, iMSB=0xFFFF -> 0x8000
//    - k=0, iMSB=0xFFFE -> 0x7FFF
//    - k=15, iMSB=3, iLSB=0x7FFF -> u=0xFFFF -> 0x8000
//  - Back-to-back: change inputs every cycle for 100 random (k, iMSB, iLSB) triples and
//    compare each against a reference model delayed by one cycle.

Source files
------------

// File: rtl/rice_demapper.sv
// ---------------------------------------------------------------------------
// rice_demapper
//   Final stage of the FLAC decoder's Rice residual path. Reassembles one
//   Rice codeword from its unary quotient and k-bit binary remainder into the
//   unsigned folded value, un-folds (zig-zag decodes) it into a signed
//   two's-complement residual and registers the result for the predictor.
//   Free-running: one codeword per clock, one clock of latency, no handshake.
//
// Ports
//   iClk        in   1        sole clock, rising edge
//   iRst        in   1        asynchronous, active-high reset (clears oData)
//   iRiceParam  in   PARAM_W  Rice parameter k of the current codeword
//   iMSB        in   DATA_W   quotient (number of unary zeros)
//   iLSB        in   DATA_W   remainder, right-aligned; bits >= k ignored
//   oData       out  DATA_W   signed residual, registered
// ---------------------------------------------------------------------------
module rice_demapper #(
    parameter int DATA_W  = 16,
    parameter int PARAM_W = 4
) (
    input  logic                     iClk,
    input  logic                     iRst,
    input  logic [PARAM_W-1:0]       iRiceParam,
    input  logic [DATA_W-1:0]        iMSB,
    input  logic [DATA_W-1:0]        iLSB,
    output logic signed [DATA_W-1:0] oData
);

    // Zig-zag decode: even codes map to non-negative values, odd codes to
    // negative ones. ~(u >> 1) equals -((u >> 1) + 1) without needing a
    // wider adder.
    function automatic logic signed [DATA_W-1:0] unfold(input logic [DATA_W-1:0] u);
        logic [DATA_W-1:0] half;
        half = u >> 1;
        return u[0] ? $signed(~half) : $signed(half);
    endfunction

    logic [DATA_W-1:0]        remMask_p0;
    logic [DATA_W-1:0]        folded_p0;
    logic signed [DATA_W-1:0] residual_p0;
    logic signed [DATA_W-1:0] residual_p1;

    // ---- stage p0: fold and unfold (combinational) ----
    // The mask is built by shifting ones left and inverting, so k=0 yields an
    // all-zero mask and quotient bits shifted past the top are simply lost.
    always_comb begin
        remMask_p0  = ~({DATA_W{1'b1}} << iRiceParam);
        folded_p0   = (iMSB << iRiceParam) | (iLSB & remMask_p0);
        residual_p0 = unfold(folded_p0);
    end

    // ---- stage p1: output register ----
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            residual_p1 <= '0;
        end else begin
            residual_p1 <= residual_p0;
        end
    end

    assign oData = residual_p1;

endmodule

// File: tb/tb_rice_demapper.sv
// ---------------------------------------------------------------------------
// tb_rice_demapper
//   Directed vectors with hand-computed expectations, plus a burst of
//   back-to-back pseudo-random codewords checked against an arithmetic
//   reference model.
// ---------------------------------------------------------------------------
module tb_rice_demapper;

    localparam int DATA_W  = 16;
    localparam int PARAM_W = 4;

    logic                     clk;
    logic                     rst;
    logic [PARAM_W-1:0]       riceParam;
    logic [DATA_W-1:0]        msb;
    logic [DATA_W-1:0]        lsb;
    logic signed [DATA_W-1:0] data;

    int checks = 0;
    int errors = 0;

    rice_demapper #(
        .DATA_W (DATA_W),
        .PARAM_W(PARAM_W)
    ) dut (
        .iClk      (clk),
        .iRst      (rst),
        .iRiceParam(riceParam),
        .iMSB      (msb),
        .iLSB      (lsb),
        .oData     (data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, obs, exp);
        end
    endtask

    // Drive one codeword, let one rising edge capture it, check just after.
    task automatic apply(input string tag, input int k, input int m, input int l,
                         input int expVal);
        logic [DATA_W-1:0] e;
        riceParam = PARAM_W'(k);
        msb       = DATA_W'(m);
        lsb       = DATA_W'(l);
        e         = DATA_W'(expVal);
        @(posedge clk);
        #1;
        chk(tag, data, e);
    endtask

    // Reference: u = msb * 2^k + (lsb mod 2^k), kept mod 2^16; even codes
    // decode to u/2, odd codes to -(u/2) - 1.
    function automatic logic [DATA_W-1:0] refModel(input int k, input int m, input int l);
        longint pw, u, r;
        pw = longint'(1) << k;
        u  = (longint'(m) * pw + (longint'(l) % pw)) % 65536;
        r  = (u % 2 == 0) ? (u / 2) : (-(u / 2) - 1);
        return DATA_W'(r);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int msbK0 [7] = '{2, 6, 3, 8, 14, 100, 203};
        int msbK3 [7] = '{0, 0, 0, 1, 1, 12, 25};
        int lsbK3 [7] = '{2, 6, 3, 0, 6, 4, 3};
        int expSeq[7] = '{1, 3, -2, 4, 7, 50, -102};

        rst       = 1'b1;
        riceParam = '0;
        msb       = '0;
        lsb       = '0;
        #2;
        chk("reset_before_edge", data, 16'h0000);
        @(posedge clk);
        #1;
        chk("reset_held", data, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("release_no_edge", data, 16'h0000);

        // k=0 sequence
        for (int i = 0; i < 7; i++)
            apply($sformatf("k0_seq%0d", i), 0, msbK0[i], 0, expSeq[i]);

        // k=3 sequence
        for (int i = 0; i < 7; i++)
            apply($sformatf("k3_seq%0d", i), 3, msbK3[i], lsbK3[i], expSeq[i]);

        // masking
        apply("mask_k3", 3, 1, 16'hFFF8, 4);
        apply("mask_k0", 0, 0, 16'hFFFF, 0);

        // extremes
        apply("ext_k0_ffff", 0, 16'hFFFF, 0, 16'h8000);
        apply("ext_k0_fffe", 0, 16'hFFFE, 0, 16'h7FFF);
        apply("ext_k15", 15, 3, 16'h7FFF, 16'h8000);
        apply("ext_zero", 5, 0, 0, 0);

        // inputs changing between edges must not disturb the output
        apply("hold_base", 0, 14, 0, 7);
        msb = 16'd100;
        #3;
        chk("hold_between_edges", data, 16'd7);
        @(posedge clk);
        #1;
        chk("hold_next_edge", data, 16'd50);

        // asynchronous reset mid-stream
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset", data, 16'h0000);
        @(posedge clk);
        #1;
        chk("reset_mid_held", data, 16'h0000);
        riceParam = 4'd0;
        msb       = 16'd203;
        #2;
        rst = 1'b0;
        #1;
        chk("reset_mid_release", data, 16'h0000);
        @(posedge clk);
        #1;
        chk("first_after_release", data, 16'hFF9A);

        // back-to-back random codewords
        for (int i = 0; i < 100; i++) begin
            int k, m, l;
            k = int'($urandom_range(0, 15));
            m = int'($urandom_range(0, 65535));
            l = int'($urandom_range(0, 65535));
            if (i % 4 == 0) m = int'($urandom_range(0, 31));
            apply($sformatf("rand%0d", i), k, m, l, int'(refModel(k, m, l)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
